// File: rtl/exec_controller.sv
// Multi-cycle A/B/accumulator controller: fetches from a combinational instruction
// memory via count, executes CLR/LDA/LDB/ADD/MUL/HALT, reports result and error.
module exec_controller #(
  parameter int unsigned W    = 4,
  parameter int unsigned PC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W-1:0]      inX,
  input  logic [3:0]        controllerInstruction,
  output logic [PC_W-1:0]   count,
  output logic [2*W-1:0]    result,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned ACC_W  = 2 * W;
  localparam int unsigned ITER_W = $clog2(W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MUL,
    S_HALT
  } state_t;

  state_t              state;
  logic [3:0]          ir;
  logic [W-1:0]        opnd;
  logic [W-1:0]        reg_a;
  logic [W-1:0]        reg_b;
  logic [ACC_W-1:0]    acc;
  logic [W-1:0]        mcand;
  logic [W-1:0]        mplier;
  logic [ITER_W-1:0]   iter;

  // Bit 3 of the opcode is a don't-care in every decode pattern below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ir     <= '0;
      opnd   <= '0;
      reg_a  <= '0;
      reg_b  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      iter   <= '0;
      count  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            count <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= controllerInstruction;
          opnd  <= inX;
          state <= S_EXEC;
        end
        S_EXEC: begin
          casez (ir)
            4'b?000: begin
              reg_a <= '0;
              reg_b <= '0;
              acc   <= '0;
              count <= count + PC_W'(1);
              state <= S_FETCH;
            end
            4'b?001: begin
              reg_a <= opnd;
              count <= count + PC_W'(1);
              state <= S_FETCH;
            end
            4'b?010: begin
              reg_b <= opnd;
              count <= count + PC_W'(1);
              state <= S_FETCH;
            end
            4'b?011: begin
              acc   <= ACC_W'(reg_a) + ACC_W'(reg_b);
              count <= count + PC_W'(1);
              state <= S_FETCH;
            end
            4'b?100: begin
              acc    <= '0;
              mcand  <= reg_a;
              mplier <= reg_b;
              iter   <= '0;
              state  <= S_MUL;
            end
            4'b?101: begin
              result <= acc;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              err   <= 1'b1;
              count <= count + PC_W'(1);
              state <= S_FETCH;
            end
          endcase
        end
        S_MUL: begin
          // Shift-add: one multiplier bit per cycle, W cycles total.
          if (mplier[0]) begin
            acc <= acc + (ACC_W'(mcand) << iter);
          end
          mplier <= mplier >> 1;
          iter   <= iter + ITER_W'(1);
          if (iter == ITER_W'(W - 1)) begin
            count <= count + PC_W'(1);
            state <= S_FETCH;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_controller.sv
// Scoreboarded bench for exec_controller: an instruction-level program model predicts
// result, err, final count and start-to-done latency for each run.
module tb_exec_controller;

  localparam int unsigned W    = 4;
  localparam int unsigned PC_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [W-1:0]      in_x;
  logic [3:0]        instr;
  logic [PC_W-1:0]   count;
  logic [2*W-1:0]    result;
  logic              busy;
  logic              done;
  logic              err;

  logic [3:0]        prog_op [8];
  logic [W-1:0]      prog_x  [8];

  always #5 clk = ~clk;

  assign instr = prog_op[count];
  assign in_x  = prog_x[count];

  exec_controller #(.W(W), .PC_W(PC_W)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .inX                   (in_x),
    .controllerInstruction (instr),
    .count                 (count),
    .result                (result),
    .busy                  (busy),
    .done                  (done),
    .err                   (err)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int result;
    int err;
    int pc;
    int cycles;
  } exp_t;

  exp_t sb[$];
  int   pc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Instruction-level interpreter with per-op latency: 2 clocks, MUL 2+W.
  function automatic exp_t model();
    exp_t e;
    int pc, a, b, acc, er, cyc;
    pc = 0; a = 0; b = 0; acc = 0; er = 0; cyc = 0;
    e.cycles = -1; e.result = 0; e.err = 0; e.pc = 0;
    for (int step = 0; step < 64; step++) begin
      cyc += 2;
      case (prog_op[pc][2:0])
        3'd0: begin a = 0; b = 0; acc = 0; end
        3'd1: a = int'(prog_x[pc]);
        3'd2: b = int'(prog_x[pc]);
        3'd3: acc = a + b;
        3'd4: begin acc = a * b; cyc += W; end
        3'd5: begin
          e.result = acc; e.err = er; e.pc = pc; e.cycles = cyc;
          return e;
        end
        default: er = 1;
      endcase
      pc = (pc + 1) % 8;
    end
    return e;
  endfunction

  task automatic set_prog(input logic [3:0] ops [8], input logic [W-1:0] xs [8]);
    for (int i = 0; i < 8; i++) begin
      prog_op[i] = ops[i];
      prog_x[i]  = xs[i];
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs the loaded program to HALT; a start pulse mid-run must be ignored.
  task automatic run_prog(input string name);
    exp_t e;
    int n;
    logic overlap;
    sb.push_back(model());
    pulse_start();
    chk({name, ".err_clr"}, 32'(err), 32'd0);
    chk({name, ".busy0"}, 32'(busy), 32'd1);
    n = 0;
    overlap = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (busy && done) overlap = 1'b1;
      start = (n == 3);
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({name, ".done"}, 32'(done), 32'd1);
    chk({name, ".result"}, 32'(result), 32'(e.result));
    chk({name, ".err"}, 32'(err), 32'(e.err));
    chk({name, ".count"}, 32'(count), 32'(e.pc));
    chk({name, ".latency"}, 32'(n), 32'(e.cycles));
    chk({name, ".excl"}, 32'(overlap), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [3:0]   ops [8];
  logic [W-1:0] xs  [8];

  initial begin
    #12;
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // CLR, LDA 2, LDB 3, ADD, MUL, HALT
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5};
    xs  = '{4'd0, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    set_prog(ops, xs);
    run_prog("addmul");

    // Reset partway through MUL of LDA 15, LDB 15, MUL, HALT
    ops = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    xs  = '{4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    set_prog(ops, xs);
    pulse_start();
    repeat (7) @(posedge clk);
    #1;
    do_reset();
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.result", 32'(result), 32'd0);
    chk("midrst.err", 32'(err), 32'd0);

    run_prog("mul15");

    // CLR, LDA 2, LDB 3, ADD, HALT
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd5, 4'd5, 4'd5};
    xs  = '{4'd0, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    set_prog(ops, xs);
    run_prog("add");

    // Illegal opcode at count 3 (bit3 set on an otherwise legal LDA elsewhere)
    ops = '{4'd0, 4'd9, 4'd2, 4'd7, 4'd3, 4'd5, 4'd5, 4'd5};
    xs  = '{4'd0, 4'd2, 4'd3, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0};
    set_prog(ops, xs);
    run_prog("illegal");

    // Multiply-by-pattern run; next start must clear the sticky err
    ops = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    xs  = '{4'd13, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    set_prog(ops, xs);
    run_prog("mul13x10");

    // No HALT: count walks 0..7 then wraps while busy stays high
    ops = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
    xs  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    set_prog(ops, xs);
    for (int i = 0; i < 10; i++) pc_q.push_back(i % 8);
    pulse_start();
    chk("wrap.count0", 32'(count), 32'(pc_q.pop_front()));
    for (int k = 1; k < 10; k++) begin
      start = (k == 4);
      @(posedge clk);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk($sformatf("wrap.count%0d", k), 32'(count), 32'(pc_q.pop_front()));
      chk($sformatf("wrap.busy%0d", k), 32'(busy), 32'd1);
    end
    chk("wrap.done", 32'(done), 32'd0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
